// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   - Op encodings driven by instruction decode onto pc_sequencer.Op.
//   - cnt_width(): width of a counter that must hold 0..depth inclusive.
package pc_pkg;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HOLD = 3'd5;

  // Counter width for values 0..depth; depth entries plus the empty state.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: parametrised LIFO holding return addresses.
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high reset, empties the stack
//   Push   - write Din on top (ignored when Full)
//   Pop    - discard top entry (ignored when Empty)
//   Din    - data to push
//   Dout   - current top-of-stack (don't-care when Empty)
//   Full   - stack holds DEPTH entries
//   Empty  - stack holds 0 entries
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned SIZE  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Push,
  input  logic            Pop,
  input  logic [SIZE-1:0] Din,
  output logic [SIZE-1:0] Dout,
  output logic            Full,
  output logic            Empty
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [CntW-1:0] count_q;
  logic [SIZE-1:0] mem_q [DEPTH];
  logic            do_push;
  logic            do_pop;
  logic [CntW-1:0] top_idx;

  assign Full    = (count_q == CntW'(DEPTH));
  assign Empty   = (count_q == '0);
  // Push wins if both are requested; the sequencer never asks for both.
  assign do_push = Push & ~Full;
  assign do_pop  = Pop & ~Empty & ~do_push;
  assign top_idx = count_q - CntW'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CntW'(1);
    end else if (do_pop) begin
      count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge Clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_push && (count_q == CntW'(i))) begin
        mem_q[i] <= Din;
      end
    end
  end

  always_comb begin
    Dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (top_idx == CntW'(i)) begin
        Dout = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register with next-PC selection (INC, JMP, BR,
// CALL, RET, HOLD), a DEPTH-entry return-address stack and a sticky error flag.
// Optional feature macro: PC_TRAP_EN (redirect to TRAP_VEC when the next PC
// exceeds TRAP_LIMIT, pulsing Trap for one cycle). Without it Trap stays 0.
// Ports:
//   Clock       - rising-edge clock
//   Reset       - synchronous active-high reset (overrides Enable/Op)
//   Enable      - 1 advances this cycle, 0 stalls all state
//   Op          - operation (see pc_pkg); 6/7 behave as INC
//   Target      - absolute address for JMP/CALL
//   Offset      - two's-complement displacement for BR
//   Cond        - branch-taken qualifier for BR
//   PC          - current program counter (registered)
//   Stack_full  - return stack holds DEPTH entries
//   Stack_empty - return stack holds 0 entries
//   Error       - sticky stack overflow/underflow flag
//   Trap        - one-cycle trap pulse
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned SIZE       = 6,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_VEC  = 0,
  parameter int unsigned TRAP_LIMIT = 2**SIZE - 1,
  parameter int unsigned TRAP_VEC   = 0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [2:0]      Op,
  input  logic [SIZE-1:0] Target,
  input  logic [SIZE-1:0] Offset,
  input  logic            Cond,
  output logic [SIZE-1:0] PC,
  output logic            Stack_full,
  output logic            Stack_empty,
  output logic            Error,
  output logic            Trap
);

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [SIZE-1:0] ResetVec  = SIZE'(RESET_VEC);
  localparam logic [SIZE-1:0] TrapLimit = SIZE'(TRAP_LIMIT);
  localparam logic [SIZE-1:0] TrapVec   = SIZE'(TRAP_VEC);

  logic [SIZE-1:0] pc_q, pc_d, pc_sel, pc_inc;
  logic            err_q, err_set;
  logic            trap_q, trap_d;
  logic            push, pop;
  logic [SIZE-1:0] stack_top;

  assign pc_inc = pc_q + SIZE'(1);

  always_comb begin
    pc_sel  = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (Op)
      OP_JMP:  pc_sel = Target;
      OP_BR:   pc_sel = Cond ? (pc_q + Offset) : pc_inc;
      OP_CALL: begin
        if (Stack_full) begin
          err_set = 1'b1;
        end else begin
          push   = 1'b1;
          pc_sel = Target;
        end
      end
      OP_RET: begin
        if (Stack_empty) begin
          err_set = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_sel = stack_top;
        end
      end
      OP_HOLD: pc_sel = pc_q;
      default: pc_sel = pc_inc;
    endcase

    // Trap redirect is applied after selection; stack effects still happen.
    trap_d = TrapEn && (pc_sel > TrapLimit);
    pc_d   = trap_d ? TrapVec : pc_sel;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q   <= ResetVec;
      err_q  <= 1'b0;
      trap_q <= 1'b0;
    end else if (Enable) begin
      pc_q   <= pc_d;
      err_q  <= err_q | err_set;
      trap_q <= trap_d;
    end else begin
      trap_q <= 1'b0;
    end
  end

  pc_ret_stack #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .Clock (Clock),
    .Reset (Reset),
    .Push  (push & Enable),
    .Pop   (pop & Enable),
    .Din   (pc_inc),
    .Dout  (stack_top),
    .Full  (Stack_full),
    .Empty (Stack_empty)
  );

  assign PC    = pc_q;
  assign Error = err_q;
  assign Trap  = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;
  localparam logic [2:0] HOLD = 3'd5, RSV6 = 3'd6;

  logic       Clock, Reset, Enable, Cond;
  logic [2:0] Op;
  logic [5:0] Target, Offset, PC;
  logic       Stack_full, Stack_empty, Error, Trap;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer #(
    .SIZE       (6),
    .DEPTH      (4),
    .RESET_VEC  (0),
    .TRAP_LIMIT (50),
    .TRAP_VEC   (7)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .Op          (Op),
    .Target      (Target),
    .Offset      (Offset),
    .Cond        (Cond),
    .PC          (PC),
    .Stack_full  (Stack_full),
    .Stack_empty (Stack_empty),
    .Error       (Error),
    .Trap        (Trap)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic [2:0] op, input logic [5:0] tgt, input logic [5:0] off,
                      input logic c, input logic en);
    Op = op; Target = tgt; Offset = off; Cond = c; Enable = en;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(INC, 6'd0, 6'd0, 1'b0, 1'b1);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (PC !== 6'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", PC); end
    n_vec++; if (Stack_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", Stack_empty); end
    n_vec++; if (Stack_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", Stack_full); end
    n_vec++; if (Error !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", Error); end
    n_vec++; if (Trap !== 1'b0) begin n_err++; $display("FAIL reset_trap: got %b want 0", Trap); end
  endtask

  task automatic test_inc_stall();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(INC, 6'd33, 6'd0, 1'b1, 1'b1);
      n_vec++; if (PC !== 6'(i)) begin n_err++; $display("FAIL inc_%0d: got %0d want %0d", i, PC, i); end
    end
    for (int i = 0; i < 2; i++) begin
      step(JMP, 6'd40, 6'd0, 1'b0, 1'b0);
      n_vec++; if (PC !== 6'd3) begin n_err++; $display("FAIL stall_%0d: got %0d want 3", i, PC); end
    end
    n_vec++; if (Stack_empty !== 1'b1 || Error !== 1'b0) begin
      n_err++; $display("FAIL inc_flags: got empty=%b err=%b want 1/0", Stack_empty, Error);
    end
  endtask

  task automatic test_jmp_wrap();
    step(JMP, 6'd62, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd62) begin n_err++; $display("FAIL jmp62: got %0d want 62", PC); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd63) begin n_err++; $display("FAIL inc63: got %0d want 63", PC); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd0) begin n_err++; $display("FAIL wrap0: got %0d want 0", PC); end
  endtask

  task automatic test_branch();
    step(JMP, 6'd10, 6'd0, 1'b0, 1'b1);
    step(BR, 6'd50, 6'h3E, 1'b1, 1'b1);
    n_vec++; if (PC !== 6'd8) begin n_err++; $display("FAIL br_taken: got %0d want 8", PC); end
    step(BR, 6'd50, 6'd5, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd9) begin n_err++; $display("FAIL br_not: got %0d want 9", PC); end
    step(BR, 6'd0, 6'd5, 1'b1, 1'b1);
    n_vec++; if (PC !== 6'd14) begin n_err++; $display("FAIL br_fwd: got %0d want 14", PC); end
    step(HOLD, 6'd20, 6'd0, 1'b1, 1'b1);
    n_vec++; if (PC !== 6'd14) begin n_err++; $display("FAIL hold: got %0d want 14", PC); end
    step(RSV6, 6'd20, 6'd0, 1'b1, 1'b1);
    n_vec++; if (PC !== 6'd15) begin n_err++; $display("FAIL rsv_inc: got %0d want 15", PC); end
  endtask

  task automatic test_call_ret();
    logic [5:0] tgts [4];
    logic [5:0] rets [4];
    tgts = '{6'd20, 6'd21, 6'd22, 6'd23};
    // Pushed return addresses are PC+1 at each CALL: 6, 21, 22, 23.
    rets = '{6'd23, 6'd22, 6'd21, 6'd6};
    do_reset();
    step(JMP, 6'd5, 6'd0, 1'b0, 1'b1);
    // A stalled CALL must not push.
    step(CALL, 6'd30, 6'd0, 1'b0, 1'b0);
    n_vec++; if (Stack_empty !== 1'b1 || PC !== 6'd5) begin
      n_err++; $display("FAIL stall_call: got empty=%b pc=%0d want 1/5", Stack_empty, PC);
    end
    for (int i = 0; i < 4; i++) begin
      step(CALL, tgts[i], 6'd0, 1'b0, 1'b1);
      n_vec++; if (PC !== tgts[i]) begin n_err++; $display("FAIL call_%0d: got %0d want %0d", i, PC, tgts[i]); end
    end
    n_vec++; if (Stack_full !== 1'b1 || Stack_empty !== 1'b0 || Error !== 1'b0) begin
      n_err++; $display("FAIL full_flags: got full=%b empty=%b err=%b want 1/0/0", Stack_full, Stack_empty, Error);
    end
    step(CALL, 6'd40, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd24 || Error !== 1'b1) begin
      n_err++; $display("FAIL overflow: got pc=%0d err=%b want 24/1", PC, Error);
    end
    for (int i = 0; i < 4; i++) begin
      step(RET, 6'd0, 6'd0, 1'b0, 1'b1);
      n_vec++; if (PC !== rets[i]) begin n_err++; $display("FAIL ret_%0d: got %0d want %0d", i, PC, rets[i]); end
    end
    n_vec++; if (Stack_empty !== 1'b1 || Stack_full !== 1'b0 || Error !== 1'b1) begin
      n_err++; $display("FAIL drained: got empty=%b full=%b err=%b want 1/0/1", Stack_empty, Stack_full, Error);
    end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    step(RET, 6'd0, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd1 || Error !== 1'b1) begin
      n_err++; $display("FAIL underflow: got pc=%0d err=%b want 1/1", PC, Error);
    end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b1);
    n_vec++; if (Error !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", Error); end
    step(CALL, 6'd12, 6'd0, 1'b0, 1'b1);
    Reset = 1'b1;
    step(CALL, 6'd33, 6'd0, 1'b0, 1'b1);
    Reset = 1'b0;
    n_vec++; if (PC !== 6'd0 || Stack_empty !== 1'b1 || Error !== 1'b0) begin
      n_err++; $display("FAIL reset_call: got pc=%0d empty=%b err=%b want 0/1/0", PC, Stack_empty, Error);
    end
  endtask

  task automatic test_trap();
    logic [5:0] exp_pc;
    logic       exp_trap;
`ifdef PC_TRAP_EN
    exp_pc = 6'd7; exp_trap = 1'b1;
`else
    exp_pc = 6'd51; exp_trap = 1'b0;
`endif
    do_reset();
    step(JMP, 6'd51, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== exp_pc || Trap !== exp_trap) begin
      n_err++; $display("FAIL trap_jmp: got pc=%0d trap=%b want %0d/%b", PC, Trap, exp_pc, exp_trap);
    end
    n_vec++; if (Error !== 1'b0) begin n_err++; $display("FAIL trap_err: got %b want 0", Error); end
    step(INC, 6'd0, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== exp_pc + 6'd1 || Trap !== 1'b0) begin
      n_err++; $display("FAIL trap_after: got pc=%0d trap=%b want %0d/0", PC, Trap, exp_pc + 6'd1);
    end
    step(JMP, 6'd50, 6'd0, 1'b0, 1'b1);
    n_vec++; if (PC !== 6'd50 || Trap !== 1'b0) begin
      n_err++; $display("FAIL trap_limit: got pc=%0d trap=%b want 50/0", PC, Trap);
    end
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b0; Op = INC; Target = '0; Offset = '0; Cond = 1'b0;
    test_reset();
    test_inc_stall();
    test_jmp_wrap();
    test_branch();
    test_call_ret();
    test_underflow_reset();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
